// File: rtl/demux1_2_stream_if.sv
// -----------------------------------------------------------------------------
// demux1_2_stream_if
//   Valid/ready stream bundle shared by the demux input and both output lanes.
//   Signals:
//     valid  producer -> consumer   beat present
//     ready  consumer -> producer   beat accepted when valid && ready
//     data   producer -> consumer   payload, DATA_W bits
//   Modports:
//     master  drives valid/data, samples ready (stream producer)
//     slave   samples valid/data, drives ready (stream consumer)
// -----------------------------------------------------------------------------
interface demux1_2_stream_if #(
    parameter int DATA_W = 8
) ();
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input  ready);
    modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/demux1_2_stream.sv
// -----------------------------------------------------------------------------
// demux1_2_stream
//   Registered 1:2 stream demultiplexer. One input stream is steered to lane 0
//   or lane 1, either by a per-beat select (mode=0) or by a round-robin
//   deinterleaver (mode=1) that recovers two channels from a time-multiplexed
//   stream. Each lane has a one-deep output register and a delivered-beat
//   counter.
//   Ports:
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset (release synchronised outside)
//     mode       0 = steer by in_select, 1 = round-robin
//     in_select  target lane when mode=0
//     in_sync    round-robin realign: this beat (or the next) goes to lane 0
//     in_bus     input stream (slave)
//     out0/out1  lane output streams (master), registered
//     cnt0/cnt1  beats delivered on each lane, wrapping
// -----------------------------------------------------------------------------
module demux1_2_stream #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic                  in_select,
    input  logic                  in_sync,
    demux1_2_stream_if.slave      in_bus,
    demux1_2_stream_if.master     out0,
    demux1_2_stream_if.master     out1,
    output logic [CNT_W-1:0]      cnt0,
    output logic [CNT_W-1:0]      cnt1
);

    typedef enum logic {
        LANE0 = 1'b0,
        LANE1 = 1'b1
    } rr_state_t;

    rr_state_t rr_state;
    rr_state_t rr_state_nxt;
    logic      rr_lane;
    logic      tgt;
    logic      accept;
    logic      load0;
    logic      load1;
    logic      drain0;
    logic      drain1;

    // Wrapping counter increment; overflow from all-ones simply drops the carry.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return c + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Steering: sync forces lane 0 in round-robin mode; only the target lane's
    // occupancy can stall the input, so a full idle lane never blocks.
    always_comb begin
        tgt           = mode ? (in_sync ? 1'b0 : rr_lane) : in_select;
        in_bus.ready  = tgt ? (!out1.valid || out1.ready)
                            : (!out0.valid || out0.ready);
        accept        = in_bus.valid && in_bus.ready;
        load0         = accept && !tgt;
        load1         = accept &&  tgt;
        drain0        = out0.valid && out0.ready;
        drain1        = out1.valid && out1.ready;
    end

    // Round-robin FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_state <= LANE0;
        else        rr_state <= rr_state_nxt;
    end

    // Round-robin FSM: next state. A sync beat lands on lane 0, so the
    // following beat belongs to lane 1; a sync with no beat just re-arms lane 0.
    // Selector mode freezes the FSM so switching back resumes the sequence.
    always_comb begin
        rr_state_nxt = rr_state;
        if (mode) begin
            if (in_sync)
                rr_state_nxt = accept ? LANE1 : LANE0;
            else if (accept)
                rr_state_nxt = (rr_state == LANE0) ? LANE1 : LANE0;
        end
    end

    // Round-robin FSM: outputs
    always_comb begin
        rr_lane = (rr_state == LANE1);
    end

    // Lane registers: a load wins over a drain so a back-to-back beat keeps
    // valid high; data only changes on load, so it is stable while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out0.valid <= 1'b0;
            out0.data  <= '0;
        end else if (load0) begin
            out0.valid <= 1'b1;
            out0.data  <= in_bus.data;
        end else if (drain0) begin
            out0.valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out1.valid <= 1'b0;
            out1.data  <= '0;
        end else if (load1) begin
            out1.valid <= 1'b1;
            out1.data  <= in_bus.data;
        end else if (drain1) begin
            out1.valid <= 1'b0;
        end
    end

    // Delivered-beat counters, independent per lane
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (drain0) cnt0 <= cnt_inc(cnt0);
            if (drain1) cnt1 <= cnt_inc(cnt1);
        end
    end

endmodule

// File: tb/tb_demux1_2_stream.sv
// -----------------------------------------------------------------------------
// tb_demux1_2_stream
//   Testbench for demux1_2_stream: a table of directed vectors, hand-written
//   wrap and async-reset sequences, then randomized traffic against a
//   queue-based reference model.
// -----------------------------------------------------------------------------
module tb_demux1_2_stream;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 8;

    logic clk;
    logic rst_n;
    logic mode;
    logic in_select;
    logic in_sync;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    demux1_2_stream_if #(.DATA_W(DATA_W)) in_bus ();
    demux1_2_stream_if #(.DATA_W(DATA_W)) out0 ();
    demux1_2_stream_if #(.DATA_W(DATA_W)) out1 ();

    demux1_2_stream #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_select (in_select),
        .in_sync   (in_sync),
        .in_bus    (in_bus),
        .out0      (out0),
        .out1      (out1),
        .cnt0      (cnt0),
        .cnt1      (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic m, input logic v, input logic [7:0] d, input logic sel,
                         input logic sy, input logic r0, input logic r1);
        mode         = m;
        in_bus.valid = v;
        in_bus.data  = d;
        in_select    = sel;
        in_sync      = sy;
        out0.ready   = r0;
        out1.ready   = r1;
    endtask

    typedef struct {
        logic       m, v;
        logic [7:0] d;
        logic       sel, sy, r0, r1;
        logic       e_rdy, e_v0;
        logic [7:0] e_d0;
        logic       e_v1;
        logic [7:0] e_d1, e_c0, e_c1;
    } vec_t;

    function automatic vec_t mk(logic m, logic v, logic [7:0] d, logic sel, logic sy,
                                logic r0, logic r1, logic e_rdy, logic e_v0, logic [7:0] e_d0,
                                logic e_v1, logic [7:0] e_d1, logic [7:0] e_c0, logic [7:0] e_c1);
        vec_t t;
        t.m = m; t.v = v; t.d = d; t.sel = sel; t.sy = sy; t.r0 = r0; t.r1 = r1;
        t.e_rdy = e_rdy; t.e_v0 = e_v0; t.e_d0 = e_d0; t.e_v1 = e_v1; t.e_d1 = e_d1;
        t.e_c0 = e_c0; t.e_c1 = e_c1;
        return t;
    endfunction

    // Called at posedge+1: drive, check in_ready mid-cycle, then check registers.
    task automatic apply_vec(input int idx, input vec_t t);
        string s;
        s = $sformatf("v%0d", idx);
        drive(t.m, t.v, t.d, t.sel, t.sy, t.r0, t.r1);
        #3;
        check({s, "_in_ready"}, 32'(in_bus.ready), 32'(t.e_rdy));
        @(posedge clk);
        #1;
        check({s, "_out0_valid"}, 32'(out0.valid), 32'(t.e_v0));
        check({s, "_out0_data"},  32'(out0.data),  32'(t.e_d0));
        check({s, "_out1_valid"}, 32'(out1.valid), 32'(t.e_v1));
        check({s, "_out1_data"},  32'(out1.data),  32'(t.e_d1));
        check({s, "_cnt0"},       32'(cnt0),       32'(t.e_c0));
        check({s, "_cnt1"},       32'(cnt1),       32'(t.e_c1));
    endtask

    // Reference model: each lane is a queue of capacity one; the round-robin
    // position is the parity of beats accepted since the last realignment.
    byte unsigned q0[$];
    byte unsigned q1[$];
    byte unsigned last0, last1;
    int           mc0, mc1;
    int           rr_count;

    task automatic model_reset();
        q0.delete(); q1.delete();
        last0 = 0; last1 = 0; mc0 = 0; mc1 = 0; rr_count = 0;
    endtask

    task automatic rand_step(input int k);
        logic m, v, sel, sy, r0, r1, lane, full, exp_rdy, acc;
        logic [7:0] d;
        string s;
        m   = ($urandom_range(0, 3) != 0);
        v   = ($urandom_range(0, 3) != 0);
        d   = 8'($urandom);
        sel = 1'($urandom);
        sy  = ($urandom_range(0, 9) == 0);
        r0  = ($urandom_range(0, 9) < 7);
        r1  = ($urandom_range(0, 9) < 7);
        drive(m, v, d, sel, sy, r0, r1);
        s = $sformatf("rnd%0d", k);

        if (m) lane = sy ? 1'b0 : 1'(rr_count % 2);
        else   lane = sel;
        full    = lane ? (q1.size() != 0) : (q0.size() != 0);
        exp_rdy = !full || (lane ? r1 : r0);
        acc     = v && exp_rdy;
        #3;
        check({s, "_in_ready"}, 32'(in_bus.ready), 32'(exp_rdy));
        @(posedge clk);
        if (q0.size() != 0 && r0) begin void'(q0.pop_front()); mc0 = (mc0 + 1) % 256; end
        if (q1.size() != 0 && r1) begin void'(q1.pop_front()); mc1 = (mc1 + 1) % 256; end
        if (acc) begin
            if (lane) begin q1.push_back(d); last1 = d; end
            else      begin q0.push_back(d); last0 = d; end
        end
        if (m) begin
            if (sy)       rr_count = acc ? 1 : 0;
            else if (acc) rr_count++;
        end
        #1;
        check({s, "_out0_valid"}, 32'(out0.valid), 32'(q0.size() != 0));
        check({s, "_out0_data"},  32'(out0.data),  32'(last0));
        check({s, "_out1_valid"}, 32'(out1.valid), 32'(q1.size() != 0));
        check({s, "_out1_data"},  32'(out1.data),  32'(last1));
        check({s, "_cnt0"},       32'(cnt0),       32'(mc0));
        check({s, "_cnt1"},       32'(cnt1),       32'(mc1));
    endtask

    vec_t tbl[27];

    initial begin
        // m v  d   sel sy r0 r1 | rdy v0 d0 v1 d1 c0 c1
        tbl[0]  = mk(0,1,8'hA5,0,0,1,1, 1,1,8'hA5,0,8'h00,8'd0,8'd0);
        tbl[1]  = mk(0,1,8'h3C,1,0,1,1, 1,0,8'hA5,1,8'h3C,8'd1,8'd0);
        tbl[2]  = mk(0,0,8'h00,0,0,1,1, 1,0,8'hA5,0,8'h3C,8'd1,8'd1);
        tbl[3]  = mk(0,1,8'h11,0,0,0,1, 1,1,8'h11,0,8'h3C,8'd1,8'd1);
        tbl[4]  = mk(0,1,8'h22,0,0,0,1, 0,1,8'h11,0,8'h3C,8'd1,8'd1);
        tbl[5]  = mk(0,1,8'h22,0,0,1,1, 1,1,8'h22,0,8'h3C,8'd2,8'd1);
        tbl[6]  = mk(0,0,8'h00,0,0,1,1, 1,0,8'h22,0,8'h3C,8'd3,8'd1);
        tbl[7]  = mk(1,1,8'h01,1,0,1,1, 1,1,8'h01,0,8'h3C,8'd3,8'd1);
        tbl[8]  = mk(1,1,8'h02,0,0,1,1, 1,0,8'h01,1,8'h02,8'd4,8'd1);
        tbl[9]  = mk(1,1,8'h03,0,0,1,1, 1,1,8'h03,0,8'h02,8'd4,8'd2);
        tbl[10] = mk(1,1,8'h04,0,0,1,1, 1,0,8'h03,1,8'h04,8'd5,8'd2);
        tbl[11] = mk(1,1,8'h05,0,0,1,1, 1,1,8'h05,0,8'h04,8'd5,8'd3);
        tbl[12] = mk(1,1,8'h06,0,0,1,1, 1,0,8'h05,1,8'h06,8'd6,8'd3);
        tbl[13] = mk(1,1,8'h0A,0,0,1,1, 1,1,8'h0A,0,8'h06,8'd6,8'd4);
        tbl[14] = mk(1,1,8'h0B,0,0,1,1, 1,0,8'h0A,1,8'h0B,8'd7,8'd4);
        tbl[15] = mk(1,1,8'h0C,0,0,1,1, 1,1,8'h0C,0,8'h0B,8'd7,8'd5);
        tbl[16] = mk(1,1,8'h07,0,1,1,1, 1,1,8'h07,0,8'h0B,8'd8,8'd5);
        tbl[17] = mk(1,1,8'h08,0,0,1,1, 1,0,8'h07,1,8'h08,8'd9,8'd5);
        tbl[18] = mk(1,1,8'h09,0,0,1,1, 1,1,8'h09,0,8'h08,8'd9,8'd6);
        tbl[19] = mk(1,0,8'h00,0,1,1,1, 1,0,8'h09,0,8'h08,8'd10,8'd6);
        tbl[20] = mk(1,1,8'h0D,0,0,1,1, 1,1,8'h0D,0,8'h08,8'd10,8'd6);
        tbl[21] = mk(0,1,8'h0E,1,0,1,1, 1,0,8'h0D,1,8'h0E,8'd11,8'd6);
        tbl[22] = mk(1,1,8'h0F,0,0,1,1, 1,0,8'h0D,1,8'h0F,8'd11,8'd7);
        tbl[23] = mk(1,1,8'h10,0,0,1,0, 1,1,8'h10,1,8'h0F,8'd11,8'd7);
        tbl[24] = mk(1,1,8'h11,0,0,0,0, 0,1,8'h10,1,8'h0F,8'd11,8'd7);
        tbl[25] = mk(1,1,8'h11,0,0,1,1, 1,0,8'h10,1,8'h11,8'd12,8'd8);
        tbl[26] = mk(0,0,8'h00,0,0,1,1, 1,0,8'h10,0,8'h11,8'd12,8'd9);

        rst_n = 1'b0;
        drive(0, 0, 8'h00, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_out0_valid", 32'(out0.valid), 32'd0);
        check("reset_out1_valid", 32'(out1.valid), 32'd0);
        check("reset_out0_data",  32'(out0.data),  32'd0);
        check("reset_cnt0",       32'(cnt0),       32'd0);
        check("reset_cnt1",       32'(cnt1),       32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) apply_vec(i, tbl[i]);

        // Counter wrap: 258 beats through lane 1 only.
        rst_n = 1'b0;
        #1;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 258; k++) begin
            drive(0, 1, 8'(k), 1, 0, 1, 1);
            @(posedge clk);
            #1;
        end
        drive(0, 0, 8'h00, 1, 0, 1, 1);
        @(posedge clk);
        #1;
        check("wrap_cnt1",       32'(cnt1),       32'd2);
        check("wrap_cnt0",       32'(cnt0),       32'd0);
        check("wrap_out1_valid", 32'(out1.valid), 32'd0);
        check("wrap_out1_data",  32'(out1.data),  32'h01);

        // Asynchronous reset with a beat held on lane 1.
        drive(0, 1, 8'h5A, 1, 0, 1, 0);
        @(posedge clk);
        #1;
        check("hold_out1_valid", 32'(out1.valid), 32'd1);
        check("hold_out1_data",  32'(out1.data),  32'h5A);
        drive(0, 0, 8'h00, 1, 0, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out1_valid", 32'(out1.valid), 32'd0);
        check("arst_out1_data",  32'(out1.data),  32'd0);
        check("arst_cnt0",       32'(cnt0),       32'd0);
        check("arst_cnt1",       32'(cnt1),       32'd0);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Randomized traffic against the reference model.
        model_reset();
        for (int k = 0; k < 600; k++) rand_step(k);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
